// File: rtl/sc_gen_pkg.sv
// Shared types and constants for the stochastic bitstream generator array.
package sc_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Generator register plus share buffer in the upstream RNG array
    localparam int unsigned RNG_LAT_DEF = 2;

    // Stream counter width: covers 0..slen+lat-1 with one spare bit
    function automatic int unsigned cnt_width(input int unsigned slen, input int unsigned lat);
        return $clog2(slen + lat) + 1;
    endfunction

endpackage

// File: rtl/sc_bitstream_gen_array_lane.sv
// One lane: latched operand and registered comparator against the lane RNG value.
module sc_cmp_lane
    import sc_gen_pkg::*;
#(
    parameter int unsigned RWID = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            sample,
    input  logic [RWID-1:0] op_in,
    input  logic [RWID-1:0] rng_in,
    output logic            bit_out
);

    logic [RWID-1:0] op_reg;

    // Capture the operand when the stream is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg <= '0;
        end else if (load) begin
            op_reg <= op_in;
        end
    end

    // Unsigned compare inside the sample window, forced low outside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_out <= 1'b0;
        end else begin
            bit_out <= sample ? (op_reg > rng_in) : 1'b0;
        end
    end

endmodule

// File: rtl/sc_bitstream_gen_array.sv
// Converts LANES binary operands into SLEN-bit unipolar stochastic streams
// using the shared RNG array; gates the RNG so each stream uses SLEN states.
module sc_bitstream_gen_array
    import sc_gen_pkg::*;
#(
    parameter int unsigned RWID    = 8,
    parameter int unsigned LANES   = 16,
    parameter int unsigned RNG_LAT = RNG_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [RWID-1:0]  inData [LANES],
    output logic             rngEnable,
    input  logic [RWID-1:0]  rngSeq [LANES],
    output logic [LANES-1:0] bitOut,
    output logic             bitValid,
    output logic             streamLast
);

    localparam int unsigned SLEN = 1 << RWID;
    localparam int unsigned CW   = cnt_width(SLEN, RNG_LAT);

    localparam logic [CW-1:0] EN_LAST   = CW'(SLEN - 1);
    localparam logic [CW-1:0] WIN_FIRST = CW'(RNG_LAT);
    localparam logic [CW-1:0] WIN_LAST  = CW'(SLEN + RNG_LAT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          sample;

    // Handshake and sample-window decode
    always_comb begin
        inReady = (state == IDLE);
        accept  = (state == IDLE) && inValid;
        sample  = (state == RUN) && (cnt >= WIN_FIRST) && (cnt <= WIN_LAST);
    end

    // Stream FSM, counter and RNG enable gating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rngEnable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    rngEnable <= inValid;
                    if (inValid) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    rngEnable <= (cnt < EN_LAST);
                    if (cnt == WIN_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    rngEnable <= 1'b0;
                end
            endcase
        end
    end

    // Output qualifiers registered alongside the lane comparators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitValid   <= 1'b0;
            streamLast <= 1'b0;
        end else begin
            bitValid   <= sample;
            streamLast <= sample && (cnt == WIN_LAST);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sc_cmp_lane #(
            .RWID(RWID)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (accept),
            .sample (sample),
            .op_in  (inData[g]),
            .rng_in (rngSeq[g]),
            .bit_out(bitOut[g])
        );
    end

endmodule
